// File: rtl/spi_pkg.sv
// spi_pkg: shared register offsets, CTRL/STATUS bit indices, FSM encoding and AHB constants for the SPI slave
package spi_pkg;
  localparam logic [1:0] SPI_REG_DATA = 2'd0;
  localparam logic [1:0] SPI_REG_CTRL = 2'd1;
  localparam logic [1:0] SPI_REG_STATUS = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_CPHA = 2;
  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL = 3;
  localparam int STAT_RXOVF = 4;
  localparam int STAT_TXUDF = 5;
  localparam int STAT_TXOVF = 6;
  localparam int STAT_BUSY = 7;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} spi_state_e;
endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI pin sync, edge detect, IDLE/LOAD/SHIFT FSM and shift regs; byte pop from TX, byte push to RX, miso/busy/underflow out
module spi_slave_shifter
  import spi_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       en_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       spi_clk_i,
  input  logic       spi_nss_i,
  input  logic       spi_mosi_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_empty_i,
  output logic       tx_pop_o,
  output logic       tx_udf_o,
  output logic       rx_push_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_miso_o
);
  spi_state_e state, nxt;
  logic [2:0] clk_q, nss_q;
  logic [1:0] mosi_q;
  logic [2:0] cnt;
  logic [7:0] rx_sr, tx_sr;
  logic cpol_l, cpha_l, toggle, lead, trail, sample, shift, nss_s, nss_fall;
  assign nss_s = nss_q[1];
  assign nss_fall = nss_q[2] & !nss_q[1];
  assign toggle = clk_q[2] ^ clk_q[1];
  assign lead = toggle & (clk_q[2] == cpol_l);
  assign trail = toggle & (clk_q[1] == cpol_l);
  assign sample = cpha_l ? trail : lead;
  assign shift = cpha_l ? lead : trail;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      clk_q <= '0;
      nss_q <= '1;
      mosi_q <= '0;
      state <= S_IDLE;
    end else begin
      clk_q <= {clk_q[1:0], spi_clk_i};
      nss_q <= {nss_q[1:0], spi_nss_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};
      state <= nxt;
    end
  always_comb
    nxt = (!en_i || nss_s) ? S_IDLE :
          (state == S_IDLE) ? (nss_fall ? S_LOAD : S_IDLE) :
          (state == S_LOAD) ? S_SHIFT :
          (sample && cnt == 3'd7) ? S_LOAD : S_SHIFT;
  always_comb begin
    tx_pop_o = state == S_LOAD && !tx_empty_i;
    tx_udf_o = state == S_LOAD && tx_empty_i;
    rx_push_o = state == S_SHIFT && sample && cnt == 3'd7 && en_i && !nss_s;
    rx_data_o = {rx_sr[6:0], mosi_q[1]};
    busy_o = state != S_IDLE;
    spi_miso_o = (!nss_s && en_i) ? tx_sr[7] : 1'b1;
  end
  // Shift edges only move data once a bit has been sampled in this frame, so
  // the first leading edge (CPHA=1) and the trailing edge after the 8th sample
  // (CPHA=0) leave the freshly loaded bit 7 on miso.
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= 8'hFF;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
    end else begin
      if (state == S_IDLE) {cpol_l, cpha_l} <= {cpol_i, cpha_i};
      if (nxt == S_IDLE) cnt <= '0;
      else if (state == S_SHIFT && sample) cnt <= cnt + 3'd1;
      if (state == S_SHIFT && sample) rx_sr <= rx_data_o;
      if (state == S_LOAD) tx_sr <= tx_empty_i ? 8'hFF : tx_data_i;
      else if (state == S_SHIFT && shift && cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b1};
    end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry FIFO; wen_i/wdata_i push, ren_i pops, rdata_o shows head, full_o/empty_o status
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              wen_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              ren_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic push, pop;
  assign push = wen_i & (!full_o | ren_i);
  assign pop = ren_i & !empty_o;
  assign empty_o = wptr == rptr;
  assign full_o = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata_o = mem[rptr[AW-1:0]];
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge hclk)
    if (push) mem[wptr[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/ahb_spi_slave.sv
// ahb_spi_slave: AHB-Lite SPI target; AHB h* ports for DATA/CTRL/STATUS, spi_clk/nss/mosi in, spi_miso out, irq_o level
module ahb_spi_slave
  import spi_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [1:0]        htrans_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [AWIDTH-1:0] haddr_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  input  logic              spi_clk_i,
  input  logic              spi_nss_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              irq_o
);
  logic dp_valid, dp_write, rd, wr, rx_pop, tx_push, ctrl_wr, stat_wr;
  logic [1:0] dp_addr;
  logic [2:0] ctrl;
  logic rxovf, txudf, txovf, busy;
  logic rx_push, rx_full, rx_empty, tx_pop, tx_udf, tx_full, tx_empty;
  logic [7:0] rx_data, rx_head, tx_head, status;
  logic unused;
  assign unused = ^{hsize_i, hburst_i, haddr_i[AWIDTH-1:4], haddr_i[1:0], hwdata_i[DWIDTH-1:8]};
  assign hreadyout_o = 1'b1;
  assign hresp_o = 1'b0;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= '0;
    end else if (hready_i) begin
      dp_valid <= hsel_i && ((htrans_i & HTRANS_NONSEQ) != 2'b00);
      dp_write <= hwrite_i;
      dp_addr <= haddr_i[3:2];
    end
  always_comb begin
    rd = dp_valid & !dp_write;
    wr = dp_valid & dp_write;
    rx_pop = rd && dp_addr == SPI_REG_DATA && !rx_empty;
    tx_push = wr && dp_addr == SPI_REG_DATA;
    ctrl_wr = wr && dp_addr == SPI_REG_CTRL;
    stat_wr = wr && dp_addr == SPI_REG_STATUS;
    status = {busy, txovf, txudf, rxovf, tx_full, tx_empty, rx_full, rx_empty};
    hrdata_o = !rd ? '0 :
               dp_addr == SPI_REG_DATA ? DWIDTH'(rx_empty ? 8'h00 : rx_head) :
               dp_addr == SPI_REG_CTRL ? DWIDTH'(ctrl) :
               dp_addr == SPI_REG_STATUS ? DWIDTH'(status) : '0;
    irq_o = (!rx_empty | rxovf | txudf | txovf) & ctrl[CTRL_EN];
  end
  // A push into a full FIFO only succeeds when the other side pops in the same cycle.
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      ctrl <= '0;
      rxovf <= 1'b0;
      txudf <= 1'b0;
      txovf <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= hwdata_i[2:0];
      rxovf <= (rxovf & !(stat_wr & hwdata_i[STAT_RXOVF])) | (rx_push & rx_full & !rx_pop);
      txudf <= (txudf & !(stat_wr & hwdata_i[STAT_TXUDF])) | tx_udf;
      txovf <= (txovf & !(stat_wr & hwdata_i[STAT_TXOVF])) | (tx_push & tx_full & !tx_pop);
    end
  sync_fifo #(.DWIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .hclk(hclk), .hresetn(hresetn), .wen_i(rx_push), .wdata_i(rx_data), .ren_i(rx_pop),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );
  sync_fifo #(.DWIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .hclk(hclk), .hresetn(hresetn), .wen_i(tx_push), .wdata_i(hwdata_i[7:0]), .ren_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );
  spi_slave_shifter u_shifter (
    .hclk(hclk), .hresetn(hresetn), .en_i(ctrl[CTRL_EN]), .cpol_i(ctrl[CTRL_CPOL]),
    .cpha_i(ctrl[CTRL_CPHA]), .spi_clk_i(spi_clk_i), .spi_nss_i(spi_nss_i),
    .spi_mosi_i(spi_mosi_i), .tx_data_i(tx_head), .tx_empty_i(tx_empty), .tx_pop_o(tx_pop),
    .tx_udf_o(tx_udf), .rx_push_o(rx_push), .rx_data_o(rx_data), .busy_o(busy),
    .spi_miso_o(spi_miso_o)
  );
endmodule

// File: tb/tb_ahb_spi_slave.sv
// tb_ahb_spi_slave: scoreboard bench; stimulus queues expected AHB reads, SPI master bytes and pin probes, a monitor compares
module tb_ahb_spi_slave;
  localparam int K_AHB = 0;
  localparam int K_SPI = 1;
  localparam int K_PIN = 2;
  localparam int HALF = 4;
  typedef struct {
    int kind;
    logic [31:0] val;
    string name;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic hclk = 0, hresetn = 0;
  logic hsel = 0, hwrite = 0, hready = 1;
  logic [1:0] htrans = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic hreadyout, hresp, irq, spi_miso;
  logic [31:0] hrdata;
  logic spi_clk = 0, spi_nss = 1, spi_mosi = 0;
  logic cpol = 0, cpha = 0;
  logic ahb_dp = 0, spi_obs = 0, probe_req = 0;
  logic [7:0] spi_obs_byte = 0;
  logic [4:0] pins;
  ahb_spi_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_i(hsel), .hwrite_i(hwrite), .hready_i(hready),
    .htrans_i(htrans), .hsize_i(3'd2), .hburst_i(3'd0), .haddr_i(haddr), .hwdata_i(hwdata),
    .hreadyout_o(hreadyout), .hresp_o(hresp), .hrdata_o(hrdata), .spi_clk_i(spi_clk),
    .spi_nss_i(spi_nss), .spi_mosi_i(spi_mosi), .spi_miso_o(spi_miso), .irq_o(irq)
  );
  always #5 hclk = ~hclk;
  assign pins = {hrdata != 32'd0, irq, spi_miso, hreadyout, hresp};
  always @(posedge hclk) ahb_dp <= hsel & hready & htrans[1] & !hwrite;
  task automatic check(input int kind, input logic [31:0] got);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected output kind=%0d got=%0h want=nothing", kind, got);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || got !== e.val) begin
        bad++;
        $display("FAIL %s: kind=%0d got=%0h want kind=%0d val=%0h", e.name, kind, got, e.kind, e.val);
      end
    end
  endtask
  always @(negedge hclk) begin
    if (ahb_dp) check(K_AHB, hrdata);
    if (spi_obs) check(K_SPI, {24'd0, spi_obs_byte});
    if (probe_req) check(K_PIN, {27'd0, pins});
  end
  task automatic push_exp(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val = val;
    e.name = name;
    q.push_back(e);
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask
  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d);
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = a;
    wait_clk(1);
    hsel = 0; htrans = 0; hwrite = 0; hwdata = d;
  endtask
  task automatic ahb_rd(input logic [31:0] a, input logic [31:0] want, input string name);
    push_exp(K_AHB, want, name);
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = a;
    wait_clk(1);
    hsel = 0; htrans = 0;
  endtask
  task automatic probe(input logic [4:0] want, input string name);
    wait_clk(1);
    push_exp(K_PIN, {27'd0, want}, name);
    probe_req = 1;
    wait_clk(1);
    probe_req = 0;
  endtask
  task automatic set_mode(input int m);
    cpol = m[1];
    cpha = m[0];
    spi_clk = cpol;
    wait_clk(4);
    ahb_wr(32'h4, {29'd0, cpha, cpol, 1'b1});
    wait_clk(2);
  endtask
  task automatic spi_bit(input logic b, output logic r);
    if (!cpha) begin
      spi_mosi = b;
      wait_clk(HALF);
      r = spi_miso;
      spi_clk = ~cpol;
      wait_clk(HALF);
      spi_clk = cpol;
    end else begin
      spi_clk = ~cpol;
      spi_mosi = b;
      wait_clk(HALF);
      r = spi_miso;
      spi_clk = cpol;
      wait_clk(HALF);
    end
  endtask
  task automatic spi_byte(input logic [7:0] mo, input logic [7:0] want, input string name);
    logic [7:0] r;
    logic b;
    push_exp(K_SPI, {24'd0, want}, name);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], b);
      r[i] = b;
    end
    spi_obs_byte = r;
    spi_obs = 1;
    wait_clk(1);
    spi_obs = 0;
  endtask
  task automatic nss_low();
    spi_nss = 0;
    wait_clk(8);
  endtask
  task automatic nss_high();
    wait_clk(4);
    spi_nss = 1;
    wait_clk(8);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic b;
    logic [7:0] mo [4];
    logic [7:0] tx [4];
    mo = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    wait_clk(3);
    probe(5'b00110, "reset_pins");
    hresetn = 1;
    wait_clk(2);
    ahb_rd(32'h8, 32'h05, "reset_status");
    ahb_rd(32'h4, 32'h00, "reset_ctrl");
    set_mode(0);
    ahb_wr(32'h0, 32'hA5);
    wait_clk(1);
    nss_low();
    spi_byte(8'h3C, 8'hA5, "mode0_miso");
    nss_high();
    ahb_rd(32'h8, 32'h24, "mode0_status");
    probe(5'b01110, "mode0_irq");
    ahb_rd(32'h0, 32'h3C, "mode0_data");
    ahb_rd(32'h8, 32'h25, "mode0_rx_empty");
    ahb_wr(32'h8, 32'h70);
    ahb_rd(32'h8, 32'h05, "mode0_clear");
    for (int m = 1; m < 4; m++) begin
      set_mode(m);
      for (int i = 0; i < 4; i++) ahb_wr(32'h0, {24'd0, tx[i]});
      wait_clk(1);
      nss_low();
      for (int i = 0; i < 4; i++) spi_byte(mo[i], tx[i], $sformatf("mode%0d_miso%0d", m, i));
      nss_high();
      ahb_rd(32'h8, 32'h24, $sformatf("mode%0d_status", m));
      for (int i = 0; i < 4; i++) ahb_rd(32'h0, {24'd0, mo[i]}, $sformatf("mode%0d_rx%0d", m, i));
      ahb_wr(32'h8, 32'h20);
      ahb_rd(32'h8, 32'h05, $sformatf("mode%0d_clear", m));
    end
    set_mode(0);
    nss_low();
    spi_byte(8'h55, 8'hFF, "udf_miso");
    nss_high();
    ahb_rd(32'h8, 32'h24, "udf_status");
    ahb_wr(32'h8, 32'h20);
    ahb_rd(32'h8, 32'h04, "udf_clear");
    ahb_rd(32'h0, 32'h55, "udf_data");
    nss_low();
    for (int i = 0; i < 17; i++) spi_byte(8'h40 + 8'(i), 8'hFF, "ovf_miso");
    nss_high();
    ahb_rd(32'h8, 32'h36, "rxovf_status");
    probe(5'b01110, "rxovf_irq");
    for (int i = 0; i < 16; i++) ahb_rd(32'h0, 32'h40 + i, $sformatf("rxovf_data%0d", i));
    ahb_rd(32'h8, 32'h35, "rxovf_drained");
    ahb_wr(32'h8, 32'h70);
    ahb_rd(32'h8, 32'h05, "rxovf_clear");
    ahb_wr(32'h0, 32'h99);
    wait_clk(1);
    nss_low();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    nss_high();
    ahb_rd(32'h8, 32'h05, "abort_status");
    ahb_wr(32'h0, 32'h5A);
    wait_clk(1);
    nss_low();
    spi_byte(8'hC3, 8'h5A, "abort_next_miso");
    nss_high();
    ahb_rd(32'h8, 32'h24, "abort_next_status");
    ahb_rd(32'h0, 32'hC3, "abort_next_data");
    probe(5'b01110, "prereset_irq");
    nss_low();
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    hresetn = 0;
    wait_clk(2);
    probe(5'b00110, "midreset_pins");
    spi_nss = 1;
    spi_clk = 0;
    wait_clk(2);
    hresetn = 1;
    wait_clk(8);
    ahb_rd(32'h4, 32'h00, "postreset_ctrl");
    ahb_rd(32'h8, 32'h05, "postreset_status");
    set_mode(0);
    ahb_wr(32'h0, 32'h81);
    wait_clk(1);
    nss_low();
    spi_byte(8'h18, 8'h81, "postreset_miso");
    nss_high();
    ahb_rd(32'h0, 32'h18, "postreset_data");
    ahb_wr(32'h8, 32'h70);
    ahb_rd(32'h8, 32'h05, "txovf_start");
    for (int i = 0; i < 16; i++) ahb_wr(32'h0, 32'hB0 + i);
    ahb_wr(32'h0, 32'hEE);
    ahb_rd(32'h8, 32'h49, "txovf_status");
    ahb_rd(32'h0, 32'h00, "rx_empty_read");
    ahb_rd(32'hC, 32'h00, "reg3_read");
    probe(5'b01110, "txovf_irq");
    nss_low();
    for (int i = 0; i < 16; i++) spi_byte(8'h00, 8'hB0 + 8'(i), $sformatf("txovf_miso%0d", i));
    nss_high();
    ahb_rd(32'h8, 32'h66, "txovf_final_status");
    wait_clk(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
